// File: rtl/hack_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hack_mem_pkg
//  Brief    : Hack data-memory map constants, region type and address decoder
//  Revision : 1.0
// ============================================================================
package hack_mem_pkg;

    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] SCR_BASE = 16'h4000;
    localparam logic [15:0] KBD_ADDR = 16'h6000;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_SCR  = 2'd1,
        REG_KBD  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    function automatic region_e decodeRegion(input logic [15:0] addr);
        if (addr[15:14] == RAM_BASE[15:14]) begin
            return REG_RAM;
        end else if (addr[15:13] == SCR_BASE[15:13]) begin
            return REG_SCR;
        end else if (addr == KBD_ADDR) begin
            return REG_KBD;
        end
        return REG_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : scr_fifo
//  Brief    : Count-based synchronous FIFO for screen updates, with drop pulse
//  Revision : 1.0
// ============================================================================
module scr_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] headData,
    output logic             drop
);

    localparam int c_ptrW = $clog2(DEPTH);
    localparam int c_cntW = c_ptrW + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_cntW-1:0] r_count;

    logic w_doPop;
    logic w_doPush;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_cntW'(DEPTH));
    assign w_doPop  = pop && !empty;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign w_doPush = push && (!full || w_doPop);
    assign drop     = push && full && !w_doPop;
    assign headData = empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_ptrW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + c_ptrW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + c_cntW'(1);
                2'b01:   r_count <= r_count - c_cntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hack_memory.sv
`default_nettype none
// ============================================================================
//  Module   : hack_memory
//  Brief    : Hack CPU data memory: RAM, screen buffer + update FIFO, keyboard
//  Revision : 1.0
// ============================================================================
module hack_memory
    import hack_mem_pkg::*;
#(
    parameter int RAM_AW     = 14,
    parameter int SCR_AW     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addressM,
    input  logic [15:0]       outM,
    input  logic              writeM,
    output logic [15:0]       inM,
    input  logic              kbd_valid,
    input  logic [15:0]       kbd_code,
    output logic              scr_valid,
    input  logic              scr_ready,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [15:0]       scr_data,
    output logic              scr_overflow
);

    localparam int c_entryW = SCR_AW + 16;

    logic [15:0] r_ram [2**RAM_AW];
    logic [15:0] r_scr [2**SCR_AW];
    logic [15:0] r_kbdReg;
    logic        r_scrOverflow;

    region_e             w_region;
    logic                w_ramWe;
    logic                w_scrWe;
    logic                w_pop;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic                w_fifoDrop;
    logic [c_entryW-1:0] w_fifoHead;

    assign w_region = decodeRegion(addressM);
    assign w_ramWe  = writeM && (w_region == REG_RAM);
    assign w_scrWe  = writeM && (w_region == REG_SCR);

    always_comb begin
        inM = '0;
        case (w_region)
            REG_RAM: inM = r_ram[addressM[RAM_AW-1:0]];
            REG_SCR: inM = r_scr[addressM[SCR_AW-1:0]];
            REG_KBD: inM = r_kbdReg;
            default: inM = '0;
        endcase
    end

    // Storage arrays are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_ramWe) begin
            r_ram[addressM[RAM_AW-1:0]] <= outM;
        end
        if (w_scrWe) begin
            r_scr[addressM[SCR_AW-1:0]] <= outM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kbdReg      <= '0;
            r_scrOverflow <= 1'b0;
        end else begin
            if (kbd_valid) begin
                r_kbdReg <= kbd_code;
            end
            if (w_fifoFull && w_fifoDrop) begin
                r_scrOverflow <= 1'b1;
            end
        end
    end

    assign scr_valid    = !w_fifoEmpty;
    assign w_pop        = scr_valid && scr_ready;
    assign scr_addr     = w_fifoHead[c_entryW-1:16];
    assign scr_data     = w_fifoHead[15:0];
    assign scr_overflow = r_scrOverflow;

    scr_fifo #(
        .WIDTH (c_entryW),
        .DEPTH (FIFO_DEPTH)
    ) u_scrFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_scrWe),
        .pushData ({addressM[SCR_AW-1:0], outM}),
        .pop      (w_pop),
        .full     (w_fifoFull),
        .empty    (w_fifoEmpty),
        .headData (w_fifoHead),
        .drop     (w_fifoDrop)
    );

endmodule
`default_nettype wire

// File: doc/hack_memory.md
# hack_memory

Data-memory responder for the Hack CPU: it services the CPU's `addressM`/`outM`/`writeM` requests and returns `inM`, implementing the standard Hack memory map. The map is RAM at 0x0000–0x3FFF, screen at 0x4000–0x5FFF and keyboard at 0x6000. Screen writes are mirrored into a local screen buffer and also queued in a small FIFO for a downstream display serializer. Keyboard codes arrive over a valid-qualified input and are latched.

## Interface
Parameters:
- `RAM_AW`, 14, RAM address width (16K words).
- `SCR_AW`, 13, screen buffer address width (8K words).
- `FIFO_DEPTH`, 4, screen-update FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `addressM`  in  16  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write strobe.
- `inM`  out  16  read data to the CPU (combinational).
- `kbd_valid`  in  1  keyboard code present this cycle.
- `kbd_code`  in  16  key code; 0 means no key.
- `scr_valid`  out  1  FIFO head is valid.
- `scr_ready`  in  1  display sink accepts the head.
- `scr_addr`  out  13  screen word offset of the head entry.
- `scr_data`  out  16  pixel word of the head entry.
- `scr_overflow`  out  1  sticky flag: a screen update was dropped.

## Operation
- Address decode on `addressM`:
  - RAM when addressM[15:14]=00.
  - Screen when addressM[15:13]=010.
  - Keyboard when addressM==0x6000.
  - Everything else is unmapped.
- Reads (`inM`) are combinational:
  - RAM → ram[addressM[13:0]].
  - Screen → scr[addressM[12:0]].
  - Keyboard → kbd_reg.
  - Unmapped → 0x0000.
- Writes with `writeM`=1:
  - RAM commits `outM` at the rising edge.
  - Screen commits to the screen buffer, and (addressM[12:0], outM) is pushed into the FIFO at the same edge.
  - Writes to the keyboard address or to unmapped addresses are ignored.
- FIFO:
  - `scr_valid` = not empty. `scr_addr`/`scr_data` show the head.
  - Pop on `scr_valid && scr_ready`.
  - Push while full: accepted only if a pop occurs in the same cycle. Otherwise the entry is dropped, the screen buffer is still updated, and `scr_overflow` sets.
  - `scr_overflow` clears only on `reset`.
- Keyboard: on any edge with `kbd_valid`=1, kbd_reg ← kbd_code. kbd_reg holds its value otherwise. A release is sent by the source as code 0.

## Timing
- Reset values:
  - kbd_reg=0.
  - FIFO empty, so `scr_valid`=0.
  - `scr_overflow`=0.
  - `scr_addr`/`scr_data` = 0.
  - RAM and screen buffer contents are not reset.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous). Queued updates are lost. No overflow is flagged.
- Read latency is 0 cycles. A read of an address written in the same cycle returns the old value; the new value is visible after the edge.
- FIFO entry latency: a pushed entry appears on `scr_valid` the cycle after the write edge. There is no bypass.
- Simultaneous push and pop when not empty: occupancy is unchanged and order is preserved.
- Pointers wrap modulo `FIFO_DEPTH`. Full/empty is determined by a count, or by an extra pointer bit.
- `scr_valid` must not depend combinationally on `scr_ready`.

## Structure
- Package `hack_mem_pkg` holds:
  - constants RAM_BASE=16'h0000, SCR_BASE=16'h4000, KBD_ADDR=16'h6000;
  - the region enum {REG_RAM, REG_SCR, REG_KBD, REG_NONE};
  - the decode function addr→region.
- Sub-module `scr_fifo` is a synchronous FIFO with `WIDTH`=29 and `DEPTH`=`FIFO_DEPTH`. Its ports are push/full/pop/empty, and it generates a drop pulse for overflow.
- RAM and screen buffer are plain arrays inside `hack_memory`, with combinational read and synchronous write.

## Test plan
- Write 0x1234 to 0x0010, then read 0x0010: `inM`=0x1234 after the edge. During the write cycle, `inM` still shows the prior value.
- Write 0xFFFF to 0x4005 with `scr_ready`=1: one cycle later `scr_valid`=1, `scr_addr`=0x0005, `scr_data`=0xFFFF. On the following edge it pops and `scr_valid`=0. A read of 0x4005 returns 0xFFFF.
- With `scr_ready`=0, issue 5 screen writes (0x4000..0x4004, data 1..5):
  - the first 4 entries are queued;
  - the 5th is dropped and `scr_overflow`=1;
  - reading 0x4004 returns 5;
  - releasing `scr_ready` drains addresses 0..3 in order.
- With the FIFO full and `scr_ready`=1, write a screen word: the push is accepted, there is no overflow, and occupancy stays at 4.
- Pulse `kbd_valid` with code 0x0083: a read of 0x6000 returns 0x0083 until a pulse with code 0 returns 0x0000. A write to 0x6000 changes nothing. A read of 0x7000 returns 0.
- Assert `reset` mid-drain with 3 entries queued: `scr_valid`, `scr_overflow` and `kbd_reg` go to 0 immediately without waiting for a clock edge, and RAM data is retained.
